// File: rtl/hack_mem_pkg.sv
// Shared memory-map definitions for the Hack-style memory system.
//
// Contents:
//   RAM_LO / RAM_HI             : general-purpose RAM window
//   SCREEN_LO_DEF / SCREEN_HI_DEF: default screen (frame buffer) window
//   KBD_ADDR                    : memory-mapped keyboard register
//   port_idx_t                  : requester port index (M0 / M1)
package hack_mem_pkg;

  localparam logic [15:0] RAM_LO        = 16'h0000;
  localparam logic [15:0] RAM_HI        = 16'h3FFF;
  localparam logic [15:0] SCREEN_LO_DEF = 16'h4000;
  localparam logic [15:0] SCREEN_HI_DEF = 16'h5FFF;
  localparam logic [15:0] KBD_ADDR      = 16'h6000;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_idx_t;

endpackage

// File: rtl/mem_region_decode.sv
// Address decoder for the screen region.
//
// Parameters:
//   ADDR_W    : address width
//   SCREEN_LO : first screen address (inclusive)
//   SCREEN_HI : last screen address (inclusive)
// Ports:
//   addr      : address to classify
//   in_screen : 1 when addr lies inside [SCREEN_LO, SCREEN_HI]
module mem_region_decode
  import hack_mem_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] SCREEN_LO = ADDR_W'(SCREEN_LO_DEF),
  parameter logic [ADDR_W-1:0] SCREEN_HI = ADDR_W'(SCREEN_HI_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_screen
);

  assign in_screen = (addr >= SCREEN_LO) && (addr <= SCREEN_HI);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory.
//
// Requester ports (k = 0, 1):
//   mk_req, mk_we, mk_addr, mk_wdata : access request (inputs)
//   mk_gnt                           : request accepted this cycle
//   mk_rvalid, mk_rdata              : read return, one cycle after grant
// Memory side:
//   mem_load, mem_address, mem_in    : access presented to the memory
//   mem_busy                         : screen region cannot take an access
//   mem_out                          : read data, one cycle after address
//
// Handshake: a requester raises mk_req with mk_we/mk_addr/mk_wdata and holds
// them stable until mk_gnt is sampled high on a rising edge; that edge is the
// transfer. mk_gnt is combinational from the request (zero added latency).
// A granted read returns exactly one mk_rvalid pulse on the following cycle
// on the same port; writes never produce mk_rvalid.
module mem_arbiter
  import hack_mem_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] SCREEN_LO = ADDR_W'(SCREEN_LO_DEF),
  parameter logic [ADDR_W-1:0] SCREEN_HI = ADDR_W'(SCREEN_HI_DEF)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_out
);

  // State
  port_idx_t         prio_q;
  logic              rd_pending_q;
  port_idx_t         rd_port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Region decode, one decoder per port
  logic in_screen0, in_screen1;

  mem_region_decode #(
    .ADDR_W   (ADDR_W),
    .SCREEN_LO(SCREEN_LO),
    .SCREEN_HI(SCREEN_HI)
  ) u_decode0 (
    .addr     (m0_addr),
    .in_screen(in_screen0)
  );

  mem_region_decode #(
    .ADDR_W   (ADDR_W),
    .SCREEN_LO(SCREEN_LO),
    .SCREEN_HI(SCREEN_HI)
  ) u_decode1 (
    .addr     (m1_addr),
    .in_screen(in_screen1)
  );

  // A busy screen only stalls requests that target the screen; the other
  // port keeps flowing.
  logic elig0, elig1;
  assign elig0 = m0_req && !(mem_busy && in_screen0);
  assign elig1 = m1_req && !(mem_busy && in_screen1);

  // Arbitration and memory-side drive
  logic              gnt_any;
  port_idx_t         gnt_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = PORT_M0;
    if (!reset) begin
      if (elig0 && elig1) begin
        gnt_any  = 1'b1;
        gnt_port = prio_q;
      end else if (elig0) begin
        gnt_any  = 1'b1;
        gnt_port = PORT_M0;
      end else if (elig1) begin
        gnt_any  = 1'b1;
        gnt_port = PORT_M1;
      end
    end

    sel_we    = (gnt_port == PORT_M1) ? m1_we    : m0_we;
    sel_addr  = (gnt_port == PORT_M1) ? m1_addr  : m0_addr;
    sel_wdata = (gnt_port == PORT_M1) ? m1_wdata : m0_wdata;

    m0_gnt   = gnt_any && (gnt_port == PORT_M0);
    m1_gnt   = gnt_any && (gnt_port == PORT_M1);
    mem_load = gnt_any && sel_we;

    // Idle cycles keep the last granted address/data on the bus.
    if (reset) begin
      mem_address = '0;
      mem_in      = '0;
    end else if (gnt_any) begin
      mem_address = sel_addr;
      mem_in      = sel_wdata;
    end else begin
      mem_address = addr_q;
      mem_in      = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q       <= PORT_M0;
      rd_pending_q <= 1'b0;
      rd_port_q    <= PORT_M0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (gnt_any) begin
      prio_q       <= (gnt_port == PORT_M0) ? PORT_M1 : PORT_M0;
      rd_pending_q <= !sel_we;
      rd_port_q    <= gnt_port;
      addr_q       <= sel_addr;
      wdata_q      <= sel_wdata;
    end else begin
      rd_pending_q <= 1'b0;
    end
  end

  // Read return. Gating with reset drops a read that was granted in the
  // cycle just before reset rose.
  assign m0_rvalid = rd_pending_q && (rd_port_q == PORT_M0) && !reset;
  assign m1_rvalid = rd_pending_q && (rd_port_q == PORT_M1) && !reset;
  assign m0_rdata  = m0_rvalid ? mem_out : '0;
  assign m1_rdata  = m1_rvalid ? mem_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a scoreboard-driven monitor.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int GW = 1 + 1 + AW + DW;  // {port, we, addr, wdata}

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_load, mem_busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in, mem_out;

  mem_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .SCREEN_LO(16'h4000),
    .SCREEN_HI(16'h5FFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .mem_load   (mem_load),
    .mem_address(mem_address),
    .mem_in     (mem_in),
    .mem_busy   (mem_busy),
    .mem_out    (mem_out)
  );

  // Memory model: 1K words aliased on addr[9:0], read data one cycle late.
  logic          mem_init;
  logic [DW-1:0] mem [0:1023];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 16'hA5A5;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(AW'(i));
    end else if (mem_load) begin
      mem[mem_address[9:0]] <= mem_in;
    end
    mem_out <= mem[mem_address[9:0]];
  end

  // Scoreboard
  logic [GW-1:0] exp_gnt_q[$];
  logic [DW-1:0] exp_rd0_q[$];
  logic [DW-1:0] exp_rd1_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_gnt(input logic port, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    exp_gnt_q.push_back({port, we, addr, wdata});
  endtask

  // Driver
  task automatic drive(input int k, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (k == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or read data.
  logic [GW-1:0] g;
  always @(negedge clk) begin
    if (m0_gnt || m1_gnt) begin
      check("single_gnt", {m0_gnt, m1_gnt} == 2'b11, 1'b0);
      if (exp_gnt_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_gnt: got m0=%0b m1=%0b expected none (t=%0t)", m0_gnt, m1_gnt, $time);
      end else begin
        g = exp_gnt_q.pop_front();
        check("gnt_port",    m1_gnt,      g[GW-1]);
        check("mem_load",    mem_load,    g[GW-2]);
        check("mem_address", mem_address, g[AW+DW-1:DW]);
        check("mem_in",      mem_in,      g[DW-1:0]);
      end
    end else begin
      check("idle_no_load", mem_load, 1'b0);
    end

    if (m0_rvalid) begin
      if (exp_rd0_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_m0_rvalid: got rdata=%0h expected no rvalid (t=%0t)", m0_rdata, $time);
      end else check("m0_rdata", m0_rdata, exp_rd0_q.pop_front());
    end else check("m0_rdata_idle", m0_rdata, 16'h0);

    if (m1_rvalid) begin
      if (exp_rd1_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_m1_rvalid: got rdata=%0h expected no rvalid (t=%0t)", m1_rdata, $time);
      end else check("m1_rdata", m1_rdata, exp_rd1_q.pop_front());
    end else check("m1_rdata_idle", m1_rdata, 16'h0);
  end

  // Time limit guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Stimulus
  int cnt0, cnt1;
  initial begin
    reset    = 1'b1;
    mem_init = 1'b1;
    mem_busy = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset: outputs forced even with a request pending
    drive(0, 1'b1, 1'b1, 16'h0077, 16'hBEEF);
    repeat (3) begin
      @(negedge clk);
      check("rst_m0_gnt",   m0_gnt,      1'b0);
      check("rst_m1_gnt",   m1_gnt,      1'b0);
      check("rst_mem_load", mem_load,    1'b0);
      check("rst_mem_addr", mem_address, 16'h0);
      check("rst_mem_in",   mem_in,      16'h0);
      check("rst_rvalid",   {m0_rvalid, m1_rvalid}, 2'b00);
    end

    // Simultaneous reads right after reset: m0 first (prio=0), then m1
    next_cycle();
    reset    = 1'b0;
    mem_init = 1'b0;
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    drive(1, 1'b1, 1'b0, 16'h0020, 16'h0);
    push_gnt(1'b0, 1'b0, 16'h0010, 16'h0);
    push_gnt(1'b1, 1'b0, 16'h0020, 16'h0);
    exp_rd0_q.push_back(init_val(16'h0010));
    exp_rd1_q.push_back(init_val(16'h0020));
    @(negedge clk);
    check("s1_t_m0_gnt", m0_gnt, 1'b1);
    check("s1_t_m1_gnt", m1_gnt, 1'b0);
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    check("s1_t1_m1_gnt",    m1_gnt,    1'b1);
    check("s1_t1_m0_rvalid", m0_rvalid, 1'b1);
    check("s1_t1_m1_rvalid", m1_rvalid, 1'b0);
    next_cycle();
    m1_req = 1'b0;
    @(negedge clk);
    check("s1_t2_m1_rvalid", m1_rvalid, 1'b1);
    check("s1_t2_m0_rvalid", m0_rvalid, 1'b0);

    // Continuous contention for 10 cycles: strict 0,1,0,1 alternation
    next_cycle();
    drive(0, 1'b1, 1'b1, 16'h0100, 16'h1111);
    drive(1, 1'b1, 1'b1, 16'h0200, 16'h2222);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) push_gnt(1'b0, 1'b1, 16'h0100, 16'h1111);
      else            push_gnt(1'b1, 1'b1, 16'h0200, 16'h2222);
    end
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("s4_m0_gnt", m0_gnt, (i % 2) == 0);
      check("s4_m1_gnt", m1_gnt, (i % 2) == 1);
      cnt0 += int'(m0_gnt);
      cnt1 += int'(m1_gnt);
    end
    check("s4_cnt0", cnt0, 5);
    check("s4_cnt1", cnt1, 5);

    // Busy screen write stalls 3 cycles, goes in the cycle busy falls
    next_cycle();
    m1_req   = 1'b0;
    mem_busy = 1'b1;
    drive(0, 1'b1, 1'b1, 16'h4000, 16'hFFFF);
    repeat (3) begin
      @(negedge clk);
      check("s2_busy_no_gnt",  m0_gnt,   1'b0);
      check("s2_busy_no_load", mem_load, 1'b0);
    end
    next_cycle();
    mem_busy = 1'b0;
    push_gnt(1'b0, 1'b1, 16'h4000, 16'hFFFF);
    @(negedge clk);
    check("s2_gnt",  m0_gnt,   1'b1);
    check("s2_load", mem_load, 1'b1);
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    check("s2_idle_load", mem_load,    1'b0);
    check("s2_hold_addr", mem_address, 16'h4000);
    check("s2_hold_in",   mem_in,      16'hFFFF);

    // Busy-stalled m0 does not block m1's RAM read
    next_cycle();
    mem_busy = 1'b1;
    drive(0, 1'b1, 1'b1, 16'h4001, 16'h0BAD);
    drive(1, 1'b1, 1'b0, 16'h0005, 16'h0);
    push_gnt(1'b1, 1'b0, 16'h0005, 16'h0);
    exp_rd1_q.push_back(init_val(16'h0005));
    @(negedge clk);
    check("s3_m1_gnt", m1_gnt, 1'b1);
    check("s3_m0_gnt", m0_gnt, 1'b0);
    next_cycle();
    m1_req = 1'b0;
    @(negedge clk);
    check("s3_m0_stalled", m0_gnt,    1'b0);
    check("s3_m1_rvalid",  m1_rvalid, 1'b1);
    next_cycle();
    mem_busy = 1'b0;
    push_gnt(1'b0, 1'b1, 16'h4001, 16'h0BAD);
    @(negedge clk);
    check("s3_m0_gnt_late", m0_gnt, 1'b1);

    // m1 read granted, then reset: its rvalid never appears
    next_cycle();
    m0_req = 1'b0;
    drive(1, 1'b1, 1'b0, 16'h0020, 16'h0);
    push_gnt(1'b1, 1'b0, 16'h0020, 16'h0);
    @(negedge clk);
    check("s5_m1_gnt", m1_gnt, 1'b1);
    next_cycle();
    m1_req = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("s5_t1_m1_rvalid", m1_rvalid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("s5_t2_m1_rvalid", m1_rvalid, 1'b0);
    next_cycle();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 16'h0030, 16'h0);
    drive(1, 1'b1, 1'b0, 16'h0040, 16'h0);
    push_gnt(1'b0, 1'b0, 16'h0030, 16'h0);
    push_gnt(1'b1, 1'b0, 16'h0040, 16'h0);
    exp_rd0_q.push_back(init_val(16'h0030));
    exp_rd1_q.push_back(init_val(16'h0040));
    @(negedge clk);
    check("s5_prio0_m0_gnt", m0_gnt, 1'b1);
    check("s5_prio0_m1_gnt", m1_gnt, 1'b0);
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    check("s5_m1_gnt2", m1_gnt, 1'b1);

    // Write then read back the same address from the other port
    next_cycle();
    m1_req = 1'b0;
    drive(0, 1'b1, 1'b1, 16'h0003, 16'h1234);
    push_gnt(1'b0, 1'b1, 16'h0003, 16'h1234);
    @(negedge clk);
    check("s6_m0_gnt", m0_gnt, 1'b1);
    next_cycle();
    m0_req = 1'b0;
    drive(1, 1'b1, 1'b0, 16'h0003, 16'h0);
    push_gnt(1'b1, 1'b0, 16'h0003, 16'h0);
    exp_rd1_q.push_back(16'h1234);
    @(negedge clk);
    check("s6_m1_gnt",    m1_gnt,    1'b1);
    check("s6_m0_rvalid", m0_rvalid, 1'b0);
    next_cycle();
    m1_req = 1'b0;
    @(negedge clk);
    check("s6_m1_rvalid",  m1_rvalid, 1'b1);
    check("s6_m0_rvalid2", m0_rvalid, 1'b0);

    // Drain and final report
    repeat (3) @(negedge clk);
    check("gnt_q_empty", exp_gnt_q.size(), 0);
    check("rd0_q_empty", exp_rd0_q.size(), 0);
    check("rd1_q_empty", exp_rd1_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
